// File: rtl/segasys1_sndlatch_if.sv
// ============================================================================
// Module      : segasys1_sndlatch_if
// Description : Command/interrupt bus between the main CPU, the sound CPU and
//               the segasys1_sndlatch block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface segasys1_sndlatch_if;
    logic       sndrq;   // main-CPU command strobe (one-cycle pulse)
    logic [7:0] sndno;   // command byte, valid with sndrq
    logic       srd;     // sound-CPU read strobe (level)
    logic       siack;   // sound-CPU interrupt acknowledge (level)
    logic [7:0] sdo;     // command byte presented to the sound CPU
    logic       snmi;    // NMI request to the sound CPU
    logic       sirq;    // periodic IRQ request to the sound CPU
    logic       pend;    // at least one unread command held
    logic       ovf;     // sticky: a command was dropped

    // CPU side: drives strobes, observes latch state
    modport master (
        output sndrq, sndno, srd, siack,
        input  sdo, snmi, sirq, pend, ovf
    );

    // Latch side
    modport slave (
        input  sndrq, sndno, srd, siack,
        output sdo, snmi, sirq, pend, ovf
    );
endinterface

`default_nettype wire

// File: rtl/segasys1_sndlatch.sv
// ============================================================================
// Module      : segasys1_sndlatch
// Description : Sega System 1 sound command latch. Holds commands written by
//               the main CPU, signals them to the sound CPU with an NMI (with
//               a guard gap between back-to-back commands) and generates the
//               periodic sound IRQ.
//               Build option: define SEGASYS1_SNDLATCH_FIFO_EN to replace the
//               single-entry latch with a 4-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module segasys1_sndlatch #(
    parameter int IRQ_PERIOD = 192000,  // 2..262143 cycles
    parameter int NMI_GAP    = 16       // 1..255 cycles
) (
    input  logic                  clk48m,
    input  logic                  reset_n,
    segasys1_sndlatch_if.slave    bus
);

    localparam logic [17:0] C_IRQ_LAST = 18'(IRQ_PERIOD - 1);
    localparam logic [7:0]  C_NMI_GAP  = 8'(NMI_GAP);

    // ------------------------------------------------------------------
    // Registers shared by both storage modes
    // ------------------------------------------------------------------
    logic        r_srd_q;
    logic        r_siack_q;
    logic [17:0] r_irq_cnt;
    logic        r_sirq;
    logic [7:0]  r_gap_cnt;
    logic        r_snmi;
    logic [7:0]  r_sdo;
    logic        r_pend;
    logic        r_ovf;

    // Storage interface: next occupancy flag, next head byte, dropped push
    logic        w_push;
    logic        w_pop;
    logic        w_next_pend;
    logic [7:0]  w_next_head;
    logic        w_drop;

    assign w_push = bus.sndrq;
    // A read completes on the falling edge of srd; reading empty storage is a no-op
    assign w_pop  = r_srd_q & ~bus.srd & r_pend;

`ifdef SEGASYS1_SNDLATCH_FIFO_EN
    // ------------------------------------------------------------------
    // 4-entry FIFO storage
    // ------------------------------------------------------------------
    logic [7:0] r_mem [4];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;

    logic       w_full;
    logic       w_push_ok;
    logic [2:0] w_remain;
    logic [2:0] w_next_count;
    logic [1:0] w_next_rd;

    assign w_full       = (r_count == 3'd4);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign w_push_ok    = w_push & (~w_full | w_pop);
    assign w_drop       = w_push & w_full & ~w_pop;
    assign w_remain     = r_count - {2'b00, w_pop};
    assign w_next_count = w_remain + {2'b00, w_push_ok};
    assign w_next_rd    = r_rd_ptr + {1'b0, w_pop};
    assign w_next_pend  = (w_next_count != 3'd0);
    // When nothing older survives this edge, the head is the byte being pushed
    assign w_next_head  = (w_remain == 3'd0) ? bus.sndno : r_mem[w_next_rd];

    // FIFO data array; contents are qualified by r_count so need no reset
    always_ff @(posedge clk48m) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.sndno;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk48m or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            r_rd_ptr <= w_next_rd;
            r_count  <= w_next_count;
        end
    end
`else
    // ------------------------------------------------------------------
    // Single-entry latch storage: a push always wins and overwrites
    // ------------------------------------------------------------------
    logic [7:0] r_entry;

    // The old byte is only lost if it was neither read nor already consumed
    assign w_drop      = w_push & r_pend & ~w_pop;
    assign w_next_pend = w_push | (r_pend & ~w_pop);
    assign w_next_head = w_push ? bus.sndno : r_entry;

    // Latch entry capture
    always_ff @(posedge clk48m or negedge reset_n) begin
        if (!reset_n) begin
            r_entry <= 8'h00;
        end else if (w_push) begin
            r_entry <= bus.sndno;
        end
    end
`endif

    // Edge-detect registers for the sound-CPU strobes
    always_ff @(posedge clk48m or negedge reset_n) begin
        if (!reset_n) begin
            r_srd_q   <= 1'b0;
            r_siack_q <= 1'b0;
        end else begin
            r_srd_q   <= bus.srd;
            r_siack_q <= bus.siack;
        end
    end

    // Occupancy flag, overflow flag and output byte; sdo frozen while srd is high
    always_ff @(posedge clk48m or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
            r_sdo  <= 8'h00;
        end else begin
            r_pend <= w_next_pend;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            // When storage empties, sdo keeps the last byte handed out
            if (!bus.srd && w_next_pend) begin
                r_sdo <= w_next_head;
            end
        end
    end

    // NMI generation: follow pend, with a fixed low gap after a pop that leaves data
    always_ff @(posedge clk48m or negedge reset_n) begin
        if (!reset_n) begin
            r_snmi    <= 1'b0;
            r_gap_cnt <= 8'd0;
        end else if (w_pop) begin
            r_snmi    <= 1'b0;
            r_gap_cnt <= w_next_pend ? C_NMI_GAP : 8'd0;
        end else if (r_gap_cnt != 8'd0) begin
            // New pushes never touch the gap counter, so the gap cannot be cut short
            r_gap_cnt <= r_gap_cnt - 8'd1;
            r_snmi    <= (r_gap_cnt == 8'd1) & r_pend;
        end else begin
            r_snmi    <= r_pend;
        end
    end

    // Free-running IRQ timer; a wrap beats a simultaneous acknowledge
    always_ff @(posedge clk48m or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_cnt <= 18'd0;
            r_sirq    <= 1'b0;
        end else begin
            if (r_irq_cnt == C_IRQ_LAST) begin
                r_irq_cnt <= 18'd0;
                r_sirq    <= 1'b1;
            end else begin
                r_irq_cnt <= r_irq_cnt + 18'd1;
                if (bus.siack && !r_siack_q) begin
                    r_sirq <= 1'b0;
                end
            end
        end
    end

    assign bus.sdo  = r_sdo;
    assign bus.snmi = r_snmi;
    assign bus.sirq = r_sirq;
    assign bus.pend = r_pend;
    assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_segasys1_sndlatch.sv
// ============================================================================
// Module      : tb_segasys1_sndlatch
// Description : Directed self-checking bench for segasys1_sndlatch
//               (IRQ_PERIOD=100, NMI_GAP=16). Storage-mode tests follow
//               SEGASYS1_SNDLATCH_FIFO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_segasys1_sndlatch;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    segasys1_sndlatch_if bus_if ();

    segasys1_sndlatch #(
        .IRQ_PERIOD (100),
        .NMI_GAP    (16)
    ) dut (
        .clk48m  (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs sampled and inputs changed 1 ns after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus_if.sndrq = 1'b1;
        bus_if.sndno = b;
        tick();
        bus_if.sndrq = 1'b0;
    endtask

    // One-cycle srd high; the pop lands on the second edge
    task automatic read_cmd;
        bus_if.srd = 1'b1;
        tick();
        bus_if.srd = 1'b0;
        tick();
    endtask

    initial begin
        bus_if.sndrq = 1'b0;
        bus_if.sndno = 8'h00;
        bus_if.srd   = 1'b0;
        bus_if.siack = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_sdo",  bus_if.sdo,  8'h00);
        check("rst_snmi", bus_if.snmi, 1'b0);
        check("rst_sirq", bus_if.sirq, 1'b0);
        check("rst_pend", bus_if.pend, 1'b0);
        check("rst_ovf",  bus_if.ovf,  1'b0);
        reset_n = 1'b1;

        // IRQ timer: first SIRQ exactly 100 edges after reset release
        repeat (99) tick();
        check("sirq_c99", bus_if.sirq, 1'b0);
        tick();
        check("sirq_c100", bus_if.sirq, 1'b1);
        repeat (5) tick();
        bus_if.siack = 1'b1;
        tick();
        check("sirq_ack", bus_if.sirq, 1'b0);
        bus_if.siack = 1'b0;
        repeat (93) tick();
        check("sirq_c199", bus_if.sirq, 1'b0);
        bus_if.siack = 1'b1;
        tick();
        check("sirq_wrap_prio", bus_if.sirq, 1'b1);
        tick();
        check("sirq_hold", bus_if.sirq, 1'b1);
        bus_if.siack = 1'b0;
        check("irq_no_pend", bus_if.pend, 1'b0);

        // Basic command: push, 3-cycle read, release
        push(8'h5A);
        check("b_pend", bus_if.pend, 1'b1);
        check("b_sdo",  bus_if.sdo,  8'h5A);
        check("b_nmi0", bus_if.snmi, 1'b0);
        tick();
        check("b_nmi1", bus_if.snmi, 1'b1);
        bus_if.srd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_sdo_rd",  bus_if.sdo,  8'h5A);
            check("b_pend_rd", bus_if.pend, 1'b1);
        end
        bus_if.srd = 1'b0;
        tick();
        check("b_pend_pop", bus_if.pend, 1'b0);
        check("b_nmi_pop",  bus_if.snmi, 1'b0);
        check("b_sdo_pop",  bus_if.sdo,  8'h5A);

`ifdef SEGASYS1_SNDLATCH_FIFO_EN
        // FIFO ordering, NMI gap, push inside the gap
        bus_if.sndrq = 1'b1;
        bus_if.sndno = 8'h11; tick();
        bus_if.sndno = 8'h22; tick();
        bus_if.sndno = 8'h33; tick();
        bus_if.sndrq = 1'b0;
        check("f_nmi",  bus_if.snmi, 1'b1);
        check("f_sdo1", bus_if.sdo,  8'h11);
        read_cmd();
        check("f_sdo2",  bus_if.sdo,  8'h22);
        check("f_nmi_p", bus_if.snmi, 1'b0);
        check("f_pend",  bus_if.pend, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            if (i == 5) begin
                bus_if.sndrq = 1'b1;
                bus_if.sndno = 8'h44;
            end
            tick();
            bus_if.sndrq = 1'b0;
            check("f_gap_low", bus_if.snmi, 1'b0);
        end
        tick();
        check("f_gap_end", bus_if.snmi, 1'b1);
        read_cmd();
        check("f_sdo3", bus_if.sdo, 8'h33);
        repeat (16) tick();
        check("f_gap2_end", bus_if.snmi, 1'b1);
        read_cmd();
        check("f_sdo4", bus_if.sdo, 8'h44);
        read_cmd();
        check("f_empty_pend", bus_if.pend, 1'b0);
        check("f_empty_sdo",  bus_if.sdo,  8'h44);

        // Full FIFO with simultaneous push and pop
        bus_if.sndrq = 1'b1;
        bus_if.sndno = 8'hA1; tick();
        bus_if.sndno = 8'hA2; tick();
        bus_if.sndno = 8'hA3; tick();
        bus_if.sndno = 8'hA4; tick();
        bus_if.sndrq = 1'b0;
        check("fp_sdo", bus_if.sdo, 8'hA1);
        bus_if.srd = 1'b1;
        tick();
        bus_if.srd   = 1'b0;
        bus_if.sndrq = 1'b1;
        bus_if.sndno = 8'hA5;
        tick();
        bus_if.sndrq = 1'b0;
        check("fp_sdo2", bus_if.sdo, 8'hA2);
        check("fp_ovf",  bus_if.ovf, 1'b0);
        read_cmd(); check("fp_sdo3", bus_if.sdo, 8'hA3);
        read_cmd(); check("fp_sdo4", bus_if.sdo, 8'hA4);
        read_cmd(); check("fp_sdo5", bus_if.sdo, 8'hA5);
        read_cmd(); check("fp_pend", bus_if.pend, 1'b0);

        // Overflow: fifth byte dropped
        bus_if.sndrq = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus_if.sndno = 8'(i);
            tick();
        end
        bus_if.sndrq = 1'b0;
        check("fo_ovf", bus_if.ovf, 1'b1);
        check("fo_sdo1", bus_if.sdo, 8'h01);
        read_cmd(); check("fo_sdo2", bus_if.sdo, 8'h02);
        read_cmd(); check("fo_sdo3", bus_if.sdo, 8'h03);
        read_cmd(); check("fo_sdo4", bus_if.sdo, 8'h04);
        read_cmd();
        check("fo_pend", bus_if.pend, 1'b0);
        check("fo_last", bus_if.sdo,  8'h04);
`else
        // Latch overwrite sets OVF
        push(8'hA0);
        tick();
        push(8'hB0);
        check("l_ovf",  bus_if.ovf,  1'b1);
        check("l_sdo",  bus_if.sdo,  8'hB0);
        check("l_pend", bus_if.pend, 1'b1);
        read_cmd();
        check("l_pend_pop", bus_if.pend, 1'b0);
        check("l_sdo_pop",  bus_if.sdo,  8'hB0);

        // Simultaneous push and pop: push wins, NMI gap follows
        push(8'hC0);
        tick();
        bus_if.srd = 1'b1;
        tick();
        bus_if.srd   = 1'b0;
        bus_if.sndrq = 1'b1;
        bus_if.sndno = 8'hD0;
        tick();
        bus_if.sndrq = 1'b0;
        check("lp_pend", bus_if.pend, 1'b1);
        check("lp_sdo",  bus_if.sdo,  8'hD0);
        check("lp_nmi",  bus_if.snmi, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("lp_gap_low", bus_if.snmi, 1'b0);
        end
        tick();
        check("lp_gap_end", bus_if.snmi, 1'b1);
        read_cmd();
        check("lp_pend_pop", bus_if.pend, 1'b0);
        check("lp_ovf_sticky", bus_if.ovf, 1'b1);
`endif

        // Reset in the middle of a read
        push(8'h7E);
        tick();
        bus_if.srd = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        check("r_sdo",  bus_if.sdo,  8'h00);
        check("r_pend", bus_if.pend, 1'b0);
        check("r_nmi",  bus_if.snmi, 1'b0);
        check("r_ovf",  bus_if.ovf,  1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        bus_if.srd = 1'b0;
        tick();
        check("r_nopop_pend", bus_if.pend, 1'b0);
        check("r_nopop_sdo",  bus_if.sdo,  8'h00);
        push(8'h3C);
        check("r_push_pend", bus_if.pend, 1'b1);
        check("r_push_sdo",  bus_if.sdo,  8'h3C);
        tick();
        check("r_push_nmi", bus_if.snmi, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/segasys1_sndlatch.md
SEGASYS1_SNDLATCH -- requirements
Module: segasys1_sndlatch

Interface
REQ-001 The block SHALL have a parameter IRQ_PERIOD, default 192000, giving the sound IRQ period in CLK48M cycles (4 ms at 48 MHz); legal range 2..262143.
REQ-002 The block SHALL have a parameter NMI_GAP, default 16, giving the SNMI low time in cycles between back-to-back commands; legal range 1..255.
REQ-003 CLK48M  in  1  single clock; all state on its rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 SNDRQ  in  1  main-CPU sound-command strobe, one-cycle pulse.
REQ-006 SNDNO  in  8  command byte, valid while SNDRQ=1.
REQ-007 SRD  in  1  sound-CPU read strobe of the command port, level, one or more cycles.
REQ-008 SIACK  in  1  sound-CPU interrupt acknowledge, level.
REQ-009 SDO  out  8  command byte presented to the sound CPU.
REQ-010 SNMI  out  1  NMI request to the sound CPU, active-high.
REQ-011 SIRQ  out  1  periodic IRQ request to the sound CPU, active-high.
REQ-012 PEND  out  1  high while at least one unread command is held.
REQ-013 OVF  out  1  sticky flag: a command was dropped.

Function
REQ-014 A push SHALL occur on every clock edge where SNDRQ=1; SNDNO is captured that edge.
REQ-015 A pop SHALL occur on the SRD 1->0 transition, detected by comparison with SRD registered one cycle earlier; a pop with PEND=0 has no effect.
REQ-016 SDO SHALL be registered, SHALL hold the oldest unread byte, and SHALL remain constant while SRD=1.
REQ-017 When PEND=0, SDO SHALL hold the last byte popped (0 after reset).
REQ-018 PEND SHALL be 1 from the cycle after a push until the cycle after the pop that empties storage.
REQ-019 SNMI SHALL rise the cycle after PEND rises and SHALL fall the cycle after a pop.
REQ-020 If PEND is still 1 after a pop, SNMI SHALL stay low for exactly NMI_GAP cycles, then rise again.
REQ-021 A push during the NMI_GAP interval SHALL NOT restart or shorten the gap.
REQ-022 An 18-bit counter SHALL count 0..IRQ_PERIOD-1 and wrap to 0.
REQ-023 SIRQ SHALL be set the cycle after the counter wraps.
REQ-024 SIRQ SHALL be cleared the cycle after an SIACK 0->1 transition.
REQ-025 If a counter wrap and an SIACK rise fall on the same edge, setting SIRQ SHALL take priority.
REQ-026 The IRQ counter SHALL run continuously, independent of the command path.

Reset
REQ-027 While RESET_N=0, SDO=0, SNMI=0, SIRQ=0, PEND=0 and OVF=0.
REQ-028 While RESET_N=0, the IRQ counter, NMI gap counter, storage pointers and SRD/SIACK edge registers SHALL be 0.
REQ-029 Assertion of RESET_N mid-read or mid-gap SHALL discard all held commands immediately.
REQ-030 After RESET_N rises, the first SIRQ SHALL occur IRQ_PERIOD cycles later.

Configuration
REQ-031 The macro SEGASYS1_SNDLATCH_FIFO_EN SHALL select the storage mode.
REQ-032 With SEGASYS1_SNDLATCH_FIFO_EN defined, storage SHALL be a 4-entry FIFO.
REQ-033 In FIFO mode, a push when 4 entries are held SHALL drop the byte and set OVF.
REQ-034 In FIFO mode, a simultaneous push and pop SHALL both take effect; the occupancy is unchanged and no overflow occurs, even when full.
REQ-035 Without the macro, storage SHALL be a single-entry latch: a push overwrites the entry and sets OVF if PEND was 1.
REQ-036 Without the macro, a simultaneous push and pop SHALL give the push priority: new byte held, PEND stays 1, SNMI follows REQ-020.

Verification
REQ-037 Reset, then pulse SNDRQ with SNDNO=0x5A -> PEND=1 and SNMI=1 one cycle later; SRD 3-cycle pulse -> SDO=0x5A throughout; after SRD falls, PEND=0 and SNMI=0.
REQ-038 FIFO mode: push 0x11,0x22,0x33 -> reads return 0x11,0x22,0x33 in order; SNMI low exactly 16 cycles between reads; after the last pop, PEND=0 and SDO=0x33.
REQ-039 FIFO mode: push 0x01..0x05 with no reads -> OVF=1; reads return 0x01..0x04 only. Latch mode: push 0xA0 then 0xB0 -> read returns 0xB0 and OVF=1.
REQ-040 IRQ_PERIOD=100: SIRQ rises at cycle 100 after reset; SIACK pulse clears it; SIACK rising on the wrap edge at cycle 200 -> SIRQ remains 1.
REQ-041 Push 0x7E, assert SRD, drop RESET_N for 2 cycles mid-read -> SDO=0, PEND=0 and SNMI=0 immediately; no pop occurs on the later SRD fall.
